// File: rtl/apb_mst_mux_pkg.sv
// apb_mst_mux_pkg
//   Shared definitions for the APB4 master bridge: FSM state encoding,
//   default parameter values (also used by the testbench) and width helpers.
package apb_mst_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_NUM_SLAVES = 4;
  localparam int APB_SEL_LSB    = 12;
  localparam int APB_TIMEOUT    = 16;

  // Width of the slave index field: max(1, clog2(n)).
  function automatic int apb_sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the wait-state counter; it must hold TIMEOUT-1.
  function automatic int apb_cnt_width(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/apb_mst_mux_addr_decoder.sv
// apb_mst_mux_addr_decoder
//   Combinational slave decode of the address index field.
//   Ports:
//     sel_field_i : index field taken from the request address
//     idx_o       : slave index
//     onehot_o    : one-hot slave select (all zero when out of range)
//     oor_o       : index does not name an existing slave
module apb_mst_mux_addr_decoder
  import apb_mst_mux_pkg::*;
#(
  parameter int NUM_SLAVES = APB_NUM_SLAVES,
  parameter int SEL_W      = apb_sel_width(APB_NUM_SLAVES)
) (
  input  logic [SEL_W-1:0]      sel_field_i,
  output logic [SEL_W-1:0]      idx_o,
  output logic [NUM_SLAVES-1:0] onehot_o,
  output logic                  oor_o
);

  localparam int            LIM_W = SEL_W + 1;
  localparam logic [SEL_W:0] LIMIT = LIM_W'(NUM_SLAVES);

  always_comb begin
    idx_o    = sel_field_i;
    // Extra MSB so NUM_SLAVES == 2**SEL_W is representable.
    oor_o    = ({1'b0, sel_field_i} >= LIMIT);
    onehot_o = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      onehot_o[k] = (sel_field_i == SEL_W'(k));
    end
  end

endmodule

// File: rtl/apb_mst_mux.sv
// apb_mst_mux
//   APB4 master bridge: converts single-word bridge requests into APB
//   SETUP/ACCESS cycles on one of NUM_SLAVES address-decoded slaves, with
//   back-to-back transfers, wait-state timeout and decode-error reporting.
//   Ports:
//     pclk, preset         : clock, asynchronous active-high reset
//     trans_i/req_ready_o  : request handshake (accepted when both high)
//     addr_i, wdata_i, wstrb_i, wr_rd_i : request payload (wr_rd_i 1 = write)
//     done_o               : one-cycle completion pulse
//     rdata_o              : last successfully read data
//     trans_err_o          : error status, valid with done_o
//     pselx, penable, pwrite, paddr, pwdata, pstrb : registered APB outputs
//     pready, pslverr, prdata : per-slave APB responses
module apb_mst_mux
  import apb_mst_mux_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int NUM_SLAVES = APB_NUM_SLAVES,
  parameter int SEL_LSB    = APB_SEL_LSB,
  parameter int TIMEOUT    = APB_TIMEOUT
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic                             trans_i,
  output logic                             req_ready_o,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  input  logic [DATA_WIDTH/8-1:0]          wstrb_i,
  input  logic                             wr_rd_i,
  output logic                             done_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             trans_err_o,
  output logic [NUM_SLAVES-1:0]            pselx,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata
);

  localparam int SEL_W  = apb_sel_width(NUM_SLAVES);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = apb_cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e              state_q;
  logic [SEL_W-1:0]        idx_q;
  logic [CNT_W-1:0]        wait_cnt_q;
  logic                    err_pend_q;
  logic [NUM_SLAVES-1:0]   pselx_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [STRB_W-1:0]       pstrb_q;
  logic                    done_q;
  logic                    trans_err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [SEL_W-1:0]        dec_idx;
  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic                    dec_oor;

  logic                    sel_pready;
  logic                    sel_pslverr;
  logic [DATA_WIDTH-1:0]   sel_prdata;
  logic                    accept;

  apb_mst_mux_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_dec (
    .sel_field_i (addr_i[SEL_LSB +: SEL_W]),
    .idx_o       (dec_idx),
    .onehot_o    (dec_onehot),
    .oor_o       (dec_oor)
  );

  // Response mux: pick the addressed slave's handshake and data.
  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == SEL_W'(k)) begin
        sel_pready  = pready[k];
        sel_pslverr = pslverr[k];
        sel_prdata  = prdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A completing ACCESS can take the next request so the bus needs no idle cycle.
  assign req_ready_o = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && sel_pready);
  assign accept      = trans_i && req_ready_o;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      err_pend_q  <= 1'b0;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      done_q      <= 1'b0;
      trans_err_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
        end

        ST_SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (sel_pready) begin
            done_q      <= 1'b1;
            trans_err_q <= sel_pslverr;
            // An errored read leaves the previous read data in place.
            if (!pwrite_q && !sel_pslverr) begin
              rdata_q <= sel_prdata;
            end
            pselx_q   <= '0;
            penable_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (wait_cnt_q == CNT_LAST) begin
            done_q      <= 1'b1;
            trans_err_q <= 1'b1;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end

        ST_ERR: begin
          // A decode error accepted behind a completing transfer reports
          // here, one cycle after that transfer's own done pulse.
          if (err_pend_q) begin
            done_q      <= 1'b1;
            trans_err_q <= 1'b1;
            err_pend_q  <= 1'b0;
          end
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase

      // New request: overrides the completion defaults set above.
      if (accept) begin
        idx_q <= dec_idx;
        if (dec_oor) begin
          // No APB cycle: bus outputs are left untouched.
          state_q <= ST_ERR;
          if (state_q == ST_IDLE) begin
            done_q      <= 1'b1;
            trans_err_q <= 1'b1;
          end else begin
            err_pend_q <= 1'b1;
          end
        end else begin
          state_q  <= ST_SETUP;
          pselx_q  <= dec_onehot;
          paddr_q  <= addr_i;
          pwrite_q <= wr_rd_i;
          pwdata_q <= wdata_i;
          pstrb_q  <= wr_rd_i ? wstrb_i : '0;
        end
      end
    end
  end

  assign pselx       = pselx_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign done_o      = done_q;
  assign trans_err_o = trans_err_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_apb_mst_mux.sv
module tb_apb_mst_mux;
  import apb_mst_mux_pkg::*;

  localparam int AW  = APB_ADDR_WIDTH;
  localparam int DW  = APB_DATA_WIDTH;
  localparam int NS  = APB_NUM_SLAVES;
  localparam int TO  = APB_TIMEOUT;
  localparam int SBW = DW / 8;

  logic pclk = 1'b0;
  logic preset = 1'b1;

  logic            trans_i = 1'b0;
  logic [AW-1:0]   addr_i = '0;
  logic [DW-1:0]   wdata_i = '0;
  logic [SBW-1:0]  wstrb_i = '0;
  logic            wr_rd_i = 1'b0;
  logic            req_ready_o, done_o, trans_err_o;
  logic [DW-1:0]   rdata_o;
  logic [NS-1:0]   pselx;
  logic            penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [SBW-1:0]  pstrb;
  logic [NS-1:0]   pready, pslverr;
  logic [NS*DW-1:0] prdata;

  // Second instance with three slaves, for the out-of-range decode case.
  logic            trans3 = 1'b0;
  logic            rdy3, done3, err3;
  logic [DW-1:0]   rdata3;
  logic [2:0]      pselx3, pready3, pslverr3;
  logic            penable3, pwrite3;
  logic [AW-1:0]   paddr3;
  logic [DW-1:0]   pwdata3;
  logic [SBW-1:0]  pstrb3;
  logic [3*DW-1:0] prdata3;

  int          ws = 0;
  logic        err_en = 1'b0;
  logic [31:0] slv_data [NS];
  int          acc_cnt;
  int          cyc = 0;
  logic [31:0] rd_mdl = '0;
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  apb_mst_mux dut (
    .pclk(pclk), .preset(preset), .trans_i(trans_i), .req_ready_o(req_ready_o),
    .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wr_rd_i(wr_rd_i),
    .done_o(done_o), .rdata_o(rdata_o), .trans_err_o(trans_err_o),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr),
    .prdata(prdata)
  );

  apb_mst_mux #(.NUM_SLAVES(3)) dut3 (
    .pclk(pclk), .preset(preset), .trans_i(trans3), .req_ready_o(rdy3),
    .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wr_rd_i(wr_rd_i),
    .done_o(done3), .rdata_o(rdata3), .trans_err_o(err3),
    .pselx(pselx3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3),
    .pwdata(pwdata3), .pstrb(pstrb3), .pready(pready3), .pslverr(pslverr3),
    .prdata(prdata3)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // Slave model: the selected slave answers after ws wait states.
  always @(posedge pclk or posedge preset) begin
    if (preset) acc_cnt <= 0;
    else if (penable && (pselx != '0) && (pready == '0)) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign pready   = pselx & {NS{penable && (acc_cnt >= ws)}};
  assign pslverr  = pselx & {NS{err_en}};
  assign prdata   = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};
  assign pready3  = pselx3 & {3{penable3}};
  assign pslverr3 = '0;
  assign prdata3  = prdata[3*DW-1:0];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Completion monitor: pops the scoreboard on every done pulse.
  always @(negedge pclk) begin
    if (!preset) begin
      chk("pselx_onehot0", 64'($onehot0(pselx)), 64'd1);
      if (done_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done_o), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("trans_err", 64'(trans_err_o), 64'(mon_e.err));
          chk("rdata", 64'(rdata_o), 64'(mon_e.rdata));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the SETUP cycle
  // (cycle 1 after accept). lat = cycles from accept to done.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, input int lat, input logic eerr);
    int   budget;
    exp_t e;
    budget  = 0;
    trans_i = 1'b1;
    addr_i  = a;
    wdata_i = d;
    wstrb_i = s;
    wr_rd_i = w;
    while (req_ready_o !== 1'b1) begin
      if (budget > 200) begin
        chk("accept_wait", 64'd0, 64'd1);
        trans_i = 1'b0;
        return;
      end
      budget++;
      @(negedge pclk);
    end
    if (!w && !eerr) rd_mdl = slv_data[a[13:12]];
    e.cyc   = cyc + lat;
    e.err   = eerr;
    e.rdata = rd_mdl;
    sb.push_back(e);
    @(negedge pclk);
    trans_i = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (sb.size() != 0) begin
      if (budget > 100) begin
        chk("idle_wait", 64'(sb.size()), 64'd0);
        sb.delete();
        return;
      end
      budget++;
      @(negedge pclk);
    end
    @(negedge pclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sl;
    int budget;
    logic wr;
    for (int k = 0; k < NS; k++) slv_data[k] = 32'hC0DE_0000 + k;

    // Reset state
    repeat (3) @(negedge pclk);
    chk("rst_pselx", 64'(pselx), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_pstrb", 64'(pstrb), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_rdata", 64'(rdata_o), 64'd0);
    chk("rst_err", 64'(trans_err_o), 64'd0);
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    preset = 1'b0;
    @(negedge pclk);

    // Zero-wait write to slave 1
    ws = 0;
    issue(32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 1'b1, 3, 1'b0);
    chk("w_setup_pselx", 64'(pselx), 64'b0010);
    chk("w_setup_penable", 64'(penable), 64'd0);
    chk("w_paddr", 64'(paddr), 64'h1004);
    chk("w_pwrite", 64'(pwrite), 64'd1);
    chk("w_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    chk("w_pstrb", 64'(pstrb), 64'hF);
    @(negedge pclk);
    chk("w_access_pselx", 64'(pselx), 64'b0010);
    chk("w_access_penable", 64'(penable), 64'd1);
    chk("w_access_ready", 64'(req_ready_o), 64'd1);
    @(negedge pclk);
    chk("w_done_pselx", 64'(pselx), 64'd0);
    chk("w_done_penable", 64'(penable), 64'd0);
    wait_idle();

    // Read from slave 3 with three wait states
    ws = 3;
    slv_data[3] = 32'h1234_5678;
    issue(32'h0000_3000, 32'h0000_0055, 4'hF, 1'b0, 6, 1'b0);
    chk("r_pselx", 64'(pselx), 64'b1000);
    chk("r_pwrite", 64'(pwrite), 64'd0);
    chk("r_pstrb", 64'(pstrb), 64'd0);
    chk("r_pwdata", 64'(pwdata), 64'h55);
    wait_idle();

    // Back-to-back writes, slave 0 then slave 2
    ws = 0;
    issue(32'h0000_0000, 32'h0000_0011, 4'h3, 1'b1, 3, 1'b0);
    issue(32'h0000_2000, 32'h0000_0022, 4'hC, 1'b1, 3, 1'b0);
    chk("b2b_pselx", 64'(pselx), 64'b0100);
    chk("b2b_penable", 64'(penable), 64'd0);
    chk("b2b_paddr", 64'(paddr), 64'h2000);
    chk("b2b_pstrb", 64'(pstrb), 64'hC);
    chk("b2b_first_done", 64'(done_o), 64'd1);
    wait_idle();

    // Slave error on a read: error flagged, read data kept
    ws = 1;
    err_en = 1'b1;
    slv_data[2] = 32'hAAAA_5555;
    issue(32'h0000_2008, 32'h0, 4'h0, 1'b0, 4, 1'b1);
    wait_idle();
    err_en = 1'b0;
    chk("slverr_rdata_kept", 64'(rdata_o), 64'h1234_5678);

    // Timeout: pready never rises
    ws = 1000;
    issue(32'h0000_0010, 32'h0000_0077, 4'hF, 1'b1, 2 + TO, 1'b1);
    budget = 0;
    while (done_o !== 1'b1 && budget < 40) begin
      budget++;
      @(negedge pclk);
    end
    chk("to_done_seen", 64'(done_o), 64'd1);
    chk("to_pselx", 64'(pselx), 64'd0);
    chk("to_penable", 64'(penable), 64'd0);
    wait_idle();

    // Mixed traffic
    for (int i = 0; i < 6; i++) begin
      sl = $urandom_range(0, NS - 1);
      wr = 1'($urandom_range(0, 1));
      ws = $urandom_range(0, 2);
      slv_data[sl] = $urandom;
      issue(32'(sl) << 12, $urandom, 4'($urandom), wr, 3 + ws, 1'b0);
      chk("mix_pselx", 64'(pselx), 64'(1) << sl);
      wait_idle();
    end

    // Decode error on the three-slave instance
    addr_i  = 32'h0000_3000;
    wr_rd_i = 1'b1;
    trans3  = 1'b1;
    chk("dec_ready", 64'(rdy3), 64'd1);
    @(negedge pclk);
    trans3 = 1'b0;
    chk("dec_done", 64'(done3), 64'd1);
    chk("dec_err", 64'(err3), 64'd1);
    chk("dec_pselx", 64'(pselx3), 64'd0);
    chk("dec_penable", 64'(penable3), 64'd0);
    chk("dec_busy", 64'(rdy3), 64'd0);
    @(negedge pclk);
    chk("dec_done_clr", 64'(done3), 64'd0);
    chk("dec_ready_again", 64'(rdy3), 64'd1);
    chk("dec_paddr_untouched", 64'(paddr3), 64'd0);

    // Reset in the middle of an ACCESS
    ws = 1000;
    issue(32'h0000_1000, 32'h0000_0099, 4'hF, 1'b0, 3, 1'b0);
    @(negedge pclk);
    chk("mid_in_access", 64'(penable), 64'd1);
    preset = 1'b1;
    #1;
    sb.delete();
    rd_mdl = '0;
    chk("mid_rst_pselx", 64'(pselx), 64'd0);
    chk("mid_rst_penable", 64'(penable), 64'd0);
    chk("mid_rst_paddr", 64'(paddr), 64'd0);
    chk("mid_rst_pwdata", 64'(pwdata), 64'd0);
    chk("mid_rst_done", 64'(done_o), 64'd0);
    chk("mid_rst_rdata", 64'(rdata_o), 64'd0);
    chk("mid_rst_err", 64'(trans_err_o), 64'd0);
    @(negedge pclk);
    preset = 1'b0;
    ws = 0;
    repeat (3) begin
      @(negedge pclk);
      chk("post_rst_no_done", 64'(done_o), 64'd0);
    end
    issue(32'h0000_1000, 32'h0000_0042, 4'h1, 1'b1, 3, 1'b0);
    wait_idle();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
